// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one matrix MAC accelerator among NUM_REQ requesters.
// Optional watchdog on the accelerator wait, enabled by defining MAC_ARB_TIMEOUT_EN.
module mac_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int K_SQUARED      = 9,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int KW = K_SQUARED * DATA_WIDTH
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*KW-1:0]   req_a,
    input  logic [NUM_REQ*KW-1:0]   req_b,
    output logic [KW-1:0]           mac_a,
    output logic [KW-1:0]           mac_b,
    output logic [K_SQUARED-1:0]    mac_start,
    input  logic [DATA_WIDTH-1:0]   mac_result,
    input  logic                    mac_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [IW-1:0]           rsp_id,
    output logic                    rsp_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, win;
    logic [KW-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic found;
`ifdef MAC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign rsp_err = 1'b0;
`endif

    // first asserted request at or after the pointer, wrapping past NUM_REQ-1
    always_comb begin
        int j;
        j = 0;
        found = 1'b0;
        win = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        rsp_id_d = rsp_id_q;
        mac_a_d = mac_a_q;
        mac_b_d = mac_b_q;
        rsp_data_d = rsp_data_q;
        req_ready = '0;
`ifdef MAC_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        rsp_err_d = rsp_err_q;
`endif
        case (state_q)
            IDLE: if (found) begin
                req_ready[win] = 1'b1;
                mac_a_d = req_a[int'(win)*KW +: KW];
                mac_b_d = req_b[int'(win)*KW +: KW];
                rsp_id_d = win;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MAC_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT: if (mac_ready) begin
                rsp_data_d = mac_result;
                state_d = RESP;
`ifdef MAC_ARB_TIMEOUT_EN
                rsp_err_d = 1'b0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                rsp_data_d = '0;
                rsp_err_d = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + CW'(1);
`endif
            end
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                ptr_d = (rsp_id_q == IW'(NUM_REQ - 1)) ? '0 : rsp_id_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            rsp_id_q <= '0;
            mac_a_q <= '0;
            mac_b_q <= '0;
            rsp_data_q <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
            cnt_q <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            rsp_id_q <= rsp_id_d;
            mac_a_q <= mac_a_d;
            mac_b_q <= mac_b_d;
            rsp_data_q <= rsp_data_d;
`ifdef MAC_ARB_TIMEOUT_EN
            cnt_q <= cnt_d;
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    assign mac_a = mac_a_q;
    assign mac_b = mac_b_q;
    assign mac_start = {K_SQUARED{state_q == ISSUE}};
    assign rsp_valid = (state_q == RESP);
    assign rsp_data = rsp_data_q;
    assign rsp_id = rsp_id_q;
endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter: grant table, directed corner sequences and random transactions
// checked against a round-robin pointer model; timeout cases need MAC_ARB_TIMEOUT_EN.
module tb_mac_share_arbiter;
    localparam int N = 4, K = 9, DW = 32, KW = K * DW, TO = 16;
    logic axi_clk = 1'b0, axi_reset_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*KW-1:0] req_a = '0, req_b = '0;
    logic [KW-1:0] mac_a, mac_b;
    logic [K-1:0] mac_start;
    logic [DW-1:0] mac_result = '0, rsp_data;
    logic mac_ready = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [1:0] rsp_id;
    int n_cmp = 0, n_err = 0, mptr = 0;

    mac_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .K_SQUARED(K), .TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start),
        .mac_result(mac_result), .mac_ready(mac_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err));

    always #5 axi_clk = ~axi_clk;

    task automatic tick;
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rv);
        for (int k = 0; k < N; k++)
            if (rv[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset;
        req_valid = '0;
        axi_reset_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mac_start", mac_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        tick;
        axi_reset_n = 1'b1;
        mptr = 0;
    endtask

    // lat < 0: accelerator never answers, expect the watchdog response
    task automatic do_txn(input logic [N-1:0] rv, input int lat, input logic [DW-1:0] res,
                          input int stall, input bit fixed, output int id);
        logic [N-1:0] er;
        logic [KW-1:0] ea, eb;
        logic [DW-1:0] ed;
        logic ee;
        int w;
        for (int i = 0; i < N * K; i++) begin
            req_a[i*DW +: DW] = fixed ? 32'd2 : $urandom;
            req_b[i*DW +: DW] = fixed ? 32'd3 : $urandom;
        end
        req_valid = rv;
        #1;
        w = pick(rv);
        id = w;
        er = (w < 0) ? '0 : (N'(1) << w);
        chk("grant", req_ready, er);
        chk("idle_rsp_valid", rsp_valid, 0);
        if (w < 0) begin
            tick;
            req_valid = '0;
            chk("idle_start", mac_start, 0);
            return;
        end
        ea = req_a[w*KW +: KW];
        eb = req_b[w*KW +: KW];
        tick;
        req_valid = rv & ~er;
        for (int i = 0; i < N * K; i++) begin
            req_a[i*DW +: DW] = $urandom;
            req_b[i*DW +: DW] = $urandom;
        end
        mac_ready = 1'b1;
        mac_result = ~res;
        #1;
        chk("issue_req_ready", req_ready, 0);
        chk("issue_start", mac_start, 9'h1FF);
        chk("mac_a", mac_a, ea);
        chk("mac_b", mac_b, eb);
        chk("issue_id", rsp_id, w);
        tick;
        mac_ready = 1'b0;
        chk("wait_start", mac_start, 0);
        if (lat < 0) begin
            repeat (TO) begin
                chk("wait_rsp_valid", rsp_valid, 0);
                tick;
            end
            ed = '0;
            ee = 1'b1;
        end else begin
            repeat (lat) begin
                chk("wait_rsp_valid", rsp_valid, 0);
                tick;
            end
            mac_ready = 1'b1;
            mac_result = res;
            tick;
            ed = res;
            ee = 1'b0;
        end
        req_valid = '1;
        for (int s = 0; s <= stall; s++) begin
            #1;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_data", rsp_data, ed);
            chk("rsp_id", rsp_id, w);
            chk("rsp_err", rsp_err, ee);
            chk("resp_req_ready", req_ready, 0);
            if (s == stall) rsp_ready = 1'b1;
            mac_ready = ~mac_ready;
            mac_result = $urandom;
            tick;
        end
        rsp_ready = 1'b0;
        mac_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("post_rsp_valid", rsp_valid, 0);
        mptr = (w + 1) % N;
    endtask

    typedef struct {
        int serve;
        logic [N-1:0] rv;
        logic [N-1:0] er;
    } vec_t;
    vec_t tbl[11];
    int id, seq[5];

    initial begin
        tbl[0] = '{-1, 4'b0100, 4'b0100};
        tbl[1] = '{-1, 4'b1010, 4'b0010};
        tbl[2] = '{-1, 4'b1111, 4'b0001};
        tbl[3] = '{-1, 4'b0000, 4'b0000};
        tbl[4] = '{0, 4'b0001, 4'b0001};
        tbl[5] = '{0, 4'b1101, 4'b0100};
        tbl[6] = '{0, 4'b1111, 4'b0010};
        tbl[7] = '{3, 4'b1000, 4'b1000};
        tbl[8] = '{3, 4'b0110, 4'b0010};
        tbl[9] = '{2, 4'b0111, 4'b0001};
        tbl[10] = '{2, 4'b1011, 4'b1000};
        #2;
        foreach (tbl[i]) begin
            do_reset;
            if (tbl[i].serve >= 0) do_txn(N'(1) << tbl[i].serve, 2, $urandom, 0, 1'b0, id);
            req_valid = tbl[i].rv;
            #1;
            chk($sformatf("tbl%0d_grant", i), req_ready, tbl[i].er);
            tick;
        end

        do_reset;
        do_txn(4'b0100, 5, 32'd54, 0, 1'b1, id);
        chk("single_id", id, 2);

        do_reset;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 1, $urandom, 0, 1'b0, seq[i]);
            chk("fair_id", seq[i], i % 4);
        end

        do_txn(4'b0001, 4, 32'hCAFE_F00D, 10, 1'b0, id);
        mac_ready = 1'b1;
        repeat (3) begin
            tick;
            chk("single_delivery", rsp_valid, 0);
        end
        mac_ready = 1'b0;

        do_reset;
        req_valid = 4'b0100;
        tick;
        req_valid = '0;
        tick;
        tick;
        #2;
        do_reset;
        req_valid = 4'b1010;
        #1;
        chk("post_reset_grant", req_ready, 4'b0010);
        do_txn(4'b1010, 3, $urandom, 1, 1'b0, id);
        chk("post_reset_id", id, 1);

`ifdef MAC_ARB_TIMEOUT_EN
        do_txn(4'b0010, -1, 0, 2, 1'b0, id);
        do_txn(4'b0010, TO - 1, 32'h1234_5678, 0, 1'b0, id);
`else
        do_txn(4'b1000, 40, 32'h0BAD_BEEF, 0, 1'b0, id);
`endif

        for (int i = 0; i < 40; i++)
            do_txn(N'($urandom_range(0, 15)), $urandom_range(0, 12), $urandom,
                   $urandom_range(0, 3), 1'b0, id);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
